// File: rtl/hvgen_pkg.sv
// ---------------------------------------------------------------------------
// hvgen_pkg
// Shared types, constants and helpers for the parametrised raster generator.
//   pos_t       : 9-bit raster coordinate (HPOS/VPOS width)
//   ADJ_MIN/MAX : range of the signed 4-bit sync-centering adjust
//   POS_LIMIT   : largest total (H or V) representable in pos_t
//   ht()/vt()   : line / frame totals from the four geometry parameters
//   sync_start(): first count of the sync pulse for a given adjust
// ---------------------------------------------------------------------------
package hvgen_pkg;

  typedef logic [8:0] pos_t;

  localparam int ADJ_MIN   = -8;
  localparam int ADJ_MAX   = 7;
  localparam int POS_LIMIT = 512;

  function automatic int ht(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int vt(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Sync start = active + front porch + signed adjust. The porch >= 8 rule
  // keeps the result positive, so plain 11-bit unsigned compares work.
  function automatic logic [10:0] sync_start(input int active, input int fp,
                                             input logic [3:0] adj);
    return 11'(active + fp) + {{7{adj[3]}}, adj};
  endfunction

endpackage

// File: rtl/hvgen_delay.sv
// ---------------------------------------------------------------------------
// hvgen_delay
// Clock-enable gated shift register used to align raster timing bits with
// late-arriving core pixels.
//   clk    : master clock
//   rst_n  : asynchronous active-low reset, loads RESET_VAL into every stage
//   ce     : shift enable (pixel clock-enable)
//   din    : WIDTH-bit input
//   dout   : din delayed by DEPTH enabled ticks (DEPTH=0 is a plain wire)
// ---------------------------------------------------------------------------
module hvgen_delay #(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    // No pipeline requested: the control inputs are intentionally ignored.
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, rst_n, ce};
    assign dout        = din;
  end else begin : g_shift
    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    // Next-state of the shift chain: stage 0 takes din, each later stage
    // takes its predecessor, all only on an enabled tick.
    always_comb begin
      stage_d = stage_q;
      if (ce) begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end
    end

    // Stage registers; reset fills the chain with the idle pattern.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q <= {DEPTH{RESET_VAL}};
      end else begin
        stage_q <= stage_d;
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/hvgen_param.sv
// ---------------------------------------------------------------------------
// hvgen_param
// Parametrised raster (H/V) timing generator running on the master clock
// and advancing on a pixel clock-enable.
//   MCLK, RESET_N   : master clock, asynchronous active-low reset
//   CE_PIX          : pixel clock-enable, one MCLK wide
//   H_ADJ, V_ADJ    : signed sync centering, latched once per frame
//   iRGB            : core pixel, PIPE ticks behind its HPOS/VPOS
//   HPOS, VPOS      : registered raster counters
//   oRGB            : blanked pixel aligned with the timing outputs
//   HBLK, VBLK      : active-high blanks; HSYN, VSYN : active-low syncs
//   VBL_STB         : one-MCLK pulse when VBLK rises
//   FRAME           : toggles each time the raster wraps to (0,0)
// ---------------------------------------------------------------------------
module hvgen_param
  import hvgen_pkg::*;
#(
  parameter int RGB_W    = 12,
  parameter int H_ACTIVE = 288,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 224,
  parameter int V_FP     = 11,
  parameter int V_SYNC   = 8,
  parameter int V_BP     = 21,
  parameter int PIPE     = 1
) (
  input  logic             MCLK,
  input  logic             RESET_N,
  input  logic             CE_PIX,
  input  logic [3:0]       H_ADJ,
  input  logic [3:0]       V_ADJ,
  input  logic [RGB_W-1:0] iRGB,
  output logic [8:0]       HPOS,
  output logic [8:0]       VPOS,
  output logic [RGB_W-1:0] oRGB,
  output logic             HBLK,
  output logic             VBLK,
  output logic             HSYN,
  output logic             VSYN,
  output logic             VBL_STB,
  output logic             FRAME
);

  localparam int HT = ht(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT = vt(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Geometry sanity: totals must fit the 9-bit counters, and the porches
  // must absorb the full adjust range so sync never enters the active area.
  if (HT > POS_LIMIT) begin : g_ht_check
    $error("hvgen_param: horizontal total exceeds 512");
  end
  if (VT > POS_LIMIT) begin : g_vt_check
    $error("hvgen_param: vertical total exceeds 512");
  end
  if (H_FP < -ADJ_MIN || H_BP < ADJ_MAX + 1) begin : g_hporch_check
    $error("hvgen_param: horizontal porches must be at least 8");
  end
  if (V_FP < -ADJ_MIN || V_BP < ADJ_MAX + 1) begin : g_vporch_check
    $error("hvgen_param: vertical porches must be at least 8");
  end
  if (PIPE < 0 || PIPE > 7) begin : g_pipe_check
    $error("hvgen_param: PIPE must be in 0..7");
  end

  localparam pos_t H_LAST = pos_t'(HT - 1);
  localparam pos_t V_LAST = pos_t'(VT - 1);

  pos_t             hcnt_q, hcnt_d;
  pos_t             vcnt_q, vcnt_d;
  logic [3:0]       ha_q, ha_d;
  logic [3:0]       va_q, va_d;
  logic [3:0]       tim_q, tim_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             frame_q, frame_d;
  logic             vbl_stb_q, vbl_stb_d;

  logic [10:0] h_ext, v_ext, hs_start, vs_start;
  logic        hb, vb, hs, vs;
  logic        line_end, frame_end;
  logic [3:0]  raw_tim, dly_tim;

  // Raw timing from the live counters. vs only depends on vcnt and va, both
  // of which change at hcnt=0, so it is naturally a per-line signal.
  always_comb begin
    h_ext    = {2'b00, hcnt_q};
    v_ext    = {2'b00, vcnt_q};
    hs_start = sync_start(H_ACTIVE, H_FP, ha_q);
    vs_start = sync_start(V_ACTIVE, V_FP, va_q);
    hb       = (h_ext >= 11'(H_ACTIVE));
    vb       = (v_ext >= 11'(V_ACTIVE));
    hs       = (h_ext >= hs_start) && (h_ext < hs_start + 11'(H_SYNC));
    vs       = (v_ext >= vs_start) && (v_ext < vs_start + 11'(V_SYNC));
    raw_tim  = {hb, vb, ~hs, ~vs};
    line_end  = (hcnt_q == H_LAST);
    frame_end = line_end && (vcnt_q == V_LAST);
  end

  // Timing bits ride a PIPE-deep chain that idles in the blanked state.
  hvgen_delay #(
    .WIDTH     (4),
    .DEPTH     (PIPE),
    .RESET_VAL (4'b1111)
  ) u_tim_dly (
    .clk   (MCLK),
    .rst_n (RESET_N),
    .ce    (CE_PIX),
    .din   (raw_tim),
    .dout  (dly_tim)
  );

  // Next-state for counters, latched adjusts and the output register. Only
  // the strobe is evaluated every MCLK so that it is always a single cycle.
  always_comb begin
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    ha_d      = ha_q;
    va_d      = va_q;
    tim_d     = tim_q;
    rgb_d     = rgb_q;
    frame_d   = frame_q;
    vbl_stb_d = 1'b0;
    if (CE_PIX) begin
      if (line_end) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 9'd1;
      end else begin
        hcnt_d = hcnt_q + 9'd1;
      end
      if (frame_end) begin
        ha_d    = H_ADJ;
        va_d    = V_ADJ;
        frame_d = ~frame_q;
      end
      tim_d     = dly_tim;
      rgb_d     = (dly_tim[3] | dly_tim[2]) ? '0 : iRGB;
      vbl_stb_d = dly_tim[2] & ~tim_q[2];
    end
  end

  // State registers; reset returns everything to the blanked idle state.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      ha_q      <= '0;
      va_q      <= '0;
      tim_q     <= 4'b1111;
      rgb_q     <= '0;
      frame_q   <= 1'b0;
      vbl_stb_q <= 1'b0;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      ha_q      <= ha_d;
      va_q      <= va_d;
      tim_q     <= tim_d;
      rgb_q     <= rgb_d;
      frame_q   <= frame_d;
      vbl_stb_q <= vbl_stb_d;
    end
  end

  assign HPOS    = hcnt_q;
  assign VPOS    = vcnt_q;
  assign HBLK    = tim_q[3];
  assign VBLK    = tim_q[2];
  assign HSYN    = tim_q[1];
  assign VSYN    = tim_q[0];
  assign oRGB    = rgb_q;
  assign VBL_STB = vbl_stb_q;
  assign FRAME   = frame_q;

endmodule
